scan_sel_counter: RTL and testbench

//   Parametrised display/lamp scan-select generator; successor of the fixed 2-bit select counter.

---
 rtl/scan_pkg.sv | 12 +
 rtl/scan_next_idx.sv | 50 +++++
 rtl/scan_sel_counter.sv | 80 ++++++++
 tb/tb_scan_sel_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared defaults and helpers for the scan-select counter.
package scan_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int PRE_W_DEF  = 8;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Circular priority search for the next enabled channel after cur (cur itself is the last candidate).
module scan_next_idx
  import scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int SEL_W = clog2_min1(NUM_CH)
) (
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [SEL_W-1:0]  nxt,
  output logic              any_en,
  output logic              wrapped
);

  logic [2*NUM_CH-1:0] dbl_s;
  logic [NUM_CH-1:0]   rot_s;
  logic [SEL_W:0]      shamt_s;
  logic [SEL_W:0]      off_s;
  logic [SEL_W:0]      sum_s;

  // Rotate the doubled mask so bit k means channel (cur+1+k) mod NUM_CH; lowest set bit wins.
  always_comb begin
    dbl_s   = {ch_en, ch_en};
    shamt_s = {1'b0, cur} + (SEL_W+1)'(1);
    rot_s   = NUM_CH'(dbl_s >> shamt_s);
    off_s   = {(SEL_W+1){1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = (SEL_W+1)'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = shamt_s + off_s;
    if (sum_s >= (SEL_W+1)'(NUM_CH)) begin
      sum_s = sum_s - (SEL_W+1)'(NUM_CH);
    end else begin
      sum_s = sum_s;
    end
    any_en = |ch_en;
    if (any_en) begin
      nxt     = SEL_W'(sum_s);
      wrapped = (SEL_W'(sum_s) <= cur);
    end else begin
      nxt     = cur;
      wrapped = 1'b0;
    end
  end

endmodule

// File: rtl/scan_sel_counter.sv
// Prescaled scan-select generator: steps sel over enabled channels with per-step and per-scan strobes.
module scan_sel_counter
  import scan_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int PRE_W      = PRE_W_DEF,
  parameter int FAST_SHIFT = 1,
  localparam int SEL_W     = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              quick,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] sel_onehot,
  output logic              tick,
  output logic              wrap
);

  localparam logic [PRE_W-1:0] NORM_MAX = {PRE_W{1'b1}};
  localparam logic [PRE_W-1:0] FAST_MAX = NORM_MAX >> FAST_SHIFT;

  logic [PRE_W-1:0] pre_r;
  logic [SEL_W-1:0] sel_r;
  logic             tick_r;
  logic             wrap_r;
  logic [PRE_W-1:0] lim_s;
  logic             step_s;
  logic [SEL_W-1:0] nxt_s;
  logic             any_en_s;
  logic             wrapped_s;

  scan_next_idx #(.NUM_CH(NUM_CH)) u_next (
    .cur     (sel_r),
    .ch_en   (ch_en),
    .nxt     (nxt_s),
    .any_en  (any_en_s),
    .wrapped (wrapped_s)
  );

  // Step decode; >= lets a quick switch with pre already past the short limit step at once.
  always_comb begin
    lim_s  = quick ? FAST_MAX : NORM_MAX;
    step_s = (pre_r >= lim_s);
  end

  // Prescaler, channel index and strobes; pause freezes state and suppresses strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r  <= {PRE_W{1'b0}};
      sel_r  <= {SEL_W{1'b0}};
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (pause) begin
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (step_s) begin
      pre_r  <= {PRE_W{1'b0}};
      sel_r  <= nxt_s;
      tick_r <= 1'b1;
      wrap_r <= wrapped_s & any_en_s;
    end else begin
      pre_r  <= pre_r + PRE_W'(1);
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end
  end

  // One-hot select gated live by ch_en so a just-disabled channel goes dark at once.
  always_comb begin
    sel_onehot        = {NUM_CH{1'b0}};
    sel_onehot[sel_r] = ch_en[sel_r];
  end

  assign sel  = sel_r;
  assign tick = tick_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_scan_sel_counter.sv
// Directed bench for scan_sel_counter at default parameters (NUM_CH=4, PRE_W=8, FAST_SHIFT=1).
module tb_scan_sel_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       quick = 1'b0;
  logic [3:0] ch_en = 4'b1111;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic       tick;
  logic       wrap;

  int compared = 0;
  int mismatched = 0;

  scan_sel_counter #(.NUM_CH(4), .PRE_W(8), .FAST_SHIFT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .quick      (quick),
    .ch_en      (ch_en),
    .sel        (sel),
    .sel_onehot (sel_onehot),
    .tick       (tick),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic run(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Counts edges until tick is seen; a 2000-edge bound returns n=2000 so the caller's check fails.
  task automatic wait_step(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (tick !== 1'b1 && n < 2000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++; if (sel !== 2'd0) begin mismatched++; $display("FAIL reset_sel: got %0d want 0", sel); end
    compared++; if (tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick: got %0b want 0", tick); end
    compared++; if (wrap !== 1'b0) begin mismatched++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    compared++; if (sel_onehot !== 4'b0001) begin mismatched++; $display("FAIL reset_onehot: got %b want 0001", sel_onehot); end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_oh  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int n;
    quick = 1'b0; ch_en = 4'b1111;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_step(n);
      compared++; if (n !== 256) begin mismatched++; $display("FAIL normal_period[%0d]: got %0d want 256", i, n); end
      compared++; if (sel !== exp_sel[i]) begin mismatched++; $display("FAIL normal_sel[%0d]: got %0d want %0d", i, sel, exp_sel[i]); end
      compared++; if (wrap !== (i == 3)) begin mismatched++; $display("FAIL normal_wrap[%0d]: got %0b want %0b", i, wrap, (i == 3)); end
      compared++; if (sel_onehot !== exp_oh[i]) begin mismatched++; $display("FAIL normal_onehot[%0d]: got %b want %b", i, sel_onehot, exp_oh[i]); end
    end
    run(1);
    compared++; if (tick !== 1'b0 || wrap !== 1'b0) begin mismatched++; $display("FAIL normal_pulse_width: got tick=%0b wrap=%0b want 0 0", tick, wrap); end
  endtask

  task automatic test_quick();
    int n;
    quick = 1'b1; ch_en = 4'b1111;
    do_reset();
    wait_step(n);
    compared++; if (n !== 128) begin mismatched++; $display("FAIL quick_period: got %0d want 128", n); end
    compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL quick_sel: got %0d want 1", sel); end
    quick = 1'b0;
    do_reset();
    run(200);
    quick = 1'b1;
    wait_step(n);
    compared++; if (n !== 1) begin mismatched++; $display("FAIL quick_switch_latency: got %0d want 1", n); end
    compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL quick_switch_sel: got %0d want 1", sel); end
    wait_step(n);
    compared++; if (n !== 128) begin mismatched++; $display("FAIL quick_after_switch: got %0d want 128", n); end
    compared++; if (sel !== 2'd2) begin mismatched++; $display("FAIL quick_after_switch_sel: got %0d want 2", sel); end
    quick = 1'b0;
  endtask

  task automatic test_sparse();
    logic [1:0] exp_sel  [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic       exp_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int n;
    ch_en = 4'b1010;
    do_reset();
    compared++; if (sel_onehot !== 4'b0000) begin mismatched++; $display("FAIL sparse_onehot_at_0: got %b want 0000", sel_onehot); end
    for (int i = 0; i < 4; i++) begin
      wait_step(n);
      compared++; if (n !== 256) begin mismatched++; $display("FAIL sparse_period[%0d]: got %0d want 256", i, n); end
      compared++; if (sel !== exp_sel[i]) begin mismatched++; $display("FAIL sparse_sel[%0d]: got %0d want %0d", i, sel, exp_sel[i]); end
      compared++; if (wrap !== exp_wrap[i]) begin mismatched++; $display("FAIL sparse_wrap[%0d]: got %0b want %0b", i, wrap, exp_wrap[i]); end
    end
    ch_en = 4'b0010;
    #1;
    compared++; if (sel_onehot !== 4'b0000) begin mismatched++; $display("FAIL sparse_live_gate: got %b want 0000", sel_onehot); end
    compared++; if (sel !== 2'd3) begin mismatched++; $display("FAIL sparse_disabled_hold: got %0d want 3", sel); end
    wait_step(n);
    compared++; if (sel !== 2'd1 || wrap !== 1'b1) begin mismatched++; $display("FAIL sparse_move_on: got sel=%0d wrap=%0b want 1 1", sel, wrap); end
    compared++; if (sel_onehot !== 4'b0010) begin mismatched++; $display("FAIL sparse_move_on_onehot: got %b want 0010", sel_onehot); end
  endtask

  task automatic test_pause();
    int n;
    int bad = 0;
    ch_en = 4'b1111;
    do_reset();
    run(250);
    pause = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (tick !== 1'b0 || sel !== 2'd0) bad++;
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL pause_hold: got %0d bad cycles want 0", bad); end
    pause = 1'b0;
    wait_step(n);
    compared++; if (n !== 6) begin mismatched++; $display("FAIL pause_resume_count: got %0d want 6", n); end
    compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL pause_resume_sel: got %0d want 1", sel); end
    run(255);
    pause = 1'b1;
    run(3);
    compared++; if (tick !== 1'b0 || sel !== 2'd1) begin mismatched++; $display("FAIL pause_wins: got tick=%0b sel=%0d want 0 1", tick, sel); end
    pause = 1'b0;
    wait_step(n);
    compared++; if (n !== 1) begin mismatched++; $display("FAIL pause_release_due: got %0d want 1", n); end
    compared++; if (sel !== 2'd2) begin mismatched++; $display("FAIL pause_release_sel: got %0d want 2", sel); end
  endtask

  task automatic test_disabled();
    int n;
    ch_en = 4'b0000;
    do_reset();
    compared++; if (sel_onehot !== 4'b0000) begin mismatched++; $display("FAIL none_onehot: got %b want 0000", sel_onehot); end
    for (int i = 0; i < 2; i++) begin
      wait_step(n);
      compared++; if (n !== 256) begin mismatched++; $display("FAIL none_period[%0d]: got %0d want 256", i, n); end
      compared++; if (sel !== 2'd0 || wrap !== 1'b0) begin mismatched++; $display("FAIL none_hold[%0d]: got sel=%0d wrap=%0b want 0 0", i, sel, wrap); end
    end
    ch_en = 4'b0100;
    #1;
    compared++; if (sel_onehot !== 4'b0000) begin mismatched++; $display("FAIL none_then_2_onehot: got %b want 0000", sel_onehot); end
    wait_step(n);
    compared++; if (n !== 256) begin mismatched++; $display("FAIL none_then_2_period: got %0d want 256", n); end
    compared++; if (sel !== 2'd2 || wrap !== 1'b0) begin mismatched++; $display("FAIL none_then_2_sel: got sel=%0d wrap=%0b want 2 0", sel, wrap); end
    compared++; if (sel_onehot !== 4'b0100) begin mismatched++; $display("FAIL none_then_2_onehot_after: got %b want 0100", sel_onehot); end
  endtask

  task automatic test_async_reset();
    int n;
    ch_en = 4'b1111;
    do_reset();
    wait_step(n);
    wait_step(n);
    run(100);
    compared++; if (sel !== 2'd2) begin mismatched++; $display("FAIL async_pre_sel: got %0d want 2", sel); end
    #2;
    rst = 1'b1;
    #1;
    compared++; if (sel !== 2'd0 || tick !== 1'b0 || wrap !== 1'b0) begin mismatched++; $display("FAIL async_clear: got sel=%0d tick=%0b wrap=%0b want 0 0 0", sel, tick, wrap); end
    compared++; if (sel_onehot !== 4'b0001) begin mismatched++; $display("FAIL async_onehot: got %b want 0001", sel_onehot); end
    #10;
    rst = 1'b0;
    wait_step(n);
    compared++; if (n !== 256) begin mismatched++; $display("FAIL async_first_step: got %0d want 256", n); end
    compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL async_first_sel: got %0d want 1", sel); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_quick();
    test_sparse();
    test_pause();
    test_disabled();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
